// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared encodings and helpers for the multi-channel NCO
package dds_pkg;

  localparam logic [1:0] CFG_FREQ  = 2'd0;
  localparam logic [1:0] CFG_PHASE = 2'd1;
  localparam logic [1:0] CFG_AMP   = 2'd2;
  localparam logic [1:0] CFG_CLR   = 2'd3;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  function automatic int unsigned midscale(input int unsigned out_w);
    return 32'd1 << (out_w - 32'd1);
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// rtl/quarter_sine_rom.sv - quarter-wave sine table, one synchronous read port
module quarter_sine_rom #(
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 8
) (
  input  logic              i_clk,
  input  logic [LUT_AW-1:0] i_addr,
  output logic [OUT_W-1:0]  o_data
);

  localparam int DEPTH = 1 << LUT_AW;

  // Spans 0..90 degrees inclusive so both the zero crossing and the peak are exact entries.
  function automatic logic [OUT_W-1:0] sine_entry(input int j);
    real peak;
    real ang;
    peak = real'((1 << (OUT_W - 1)) - 1);
    ang  = 1.5707963267948966 * real'(j) / real'(DEPTH - 1);
    return OUT_W'($rtoi(peak * $sin(ang) + 0.5));
  endfunction

  logic [OUT_W-1:0] w_table [DEPTH];
  logic [OUT_W-1:0] r_data;

  for (genvar j = 0; j < DEPTH; j++) begin : g_rom
    assign w_table[j] = sine_entry(j);
  end

  always_ff @(posedge i_clk) begin
    r_data <= w_table[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/dds_nco_mc.sv
// rtl/dds_nco_mc.sv - multi-channel NCO: shadow registers, round-robin scan, 3-stage sine pipeline
module dds_nco_mc
  import dds_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 32,
  parameter int LUT_AW   = 8,
  parameter int OUT_W    = 8,
  parameter int AMP_W    = 8
) (
  input  logic             i_src_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_tick,
  input  logic             i_sync,
  input  logic             i_cfg_we,
  input  logic [3:0]       i_cfg_ch,
  input  logic [1:0]       i_cfg_sel,
  input  logic [31:0]      i_cfg_data,
  output logic [OUT_W-1:0] o_sample,
  output logic [3:0]       o_sample_ch,
  output logic             o_sample_valid,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int               PW      = LUT_AW + 2;
  localparam logic [OUT_W-1:0] MID     = OUT_W'(midscale(OUT_W));
  localparam logic [3:0]       CH_LAST = 4'(CHANNELS - 1);

  logic [ACC_W-1:0] r_freq_sh  [CHANNELS];
  logic [PW-1:0]    r_phase_sh [CHANNELS];
  logic [AMP_W-1:0] r_amp_sh   [CHANNELS];
  logic [ACC_W-1:0] r_acc      [CHANNELS];
  logic [ACC_W-1:0] w_acc_next [CHANNELS];
  logic [PW-1:0]    r_scan_pos   [CHANNELS];
  logic [PW-1:0]    r_scan_phase [CHANNELS];
  logic [AMP_W-1:0] r_scan_amp   [CHANNELS];

  scan_state_t r_state;
  logic [3:0]  r_scan_ch;
  logic [1:0]  r_drain_cnt;
  logic        r_busy;
  logic        r_overrun;

  logic w_cfg_wr;
  logic w_accept;
  logic w_overrun_set;

  assign w_cfg_wr      = i_cfg_we && (i_cfg_sel != CFG_CLR);
  assign w_accept      = i_en && i_tick && !r_busy && !i_sync;
  assign w_overrun_set = i_en && i_tick && r_busy && !i_sync;

  // Writes to channels that do not exist match no index and fall away.
  always_ff @(posedge i_src_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_freq_sh[c]  <= '0;
        r_phase_sh[c] <= '0;
        r_amp_sh[c]   <= '1;
      end
    end else if (w_cfg_wr) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (i_cfg_ch == 4'(c)) begin
          case (i_cfg_sel)
            CFG_FREQ:  r_freq_sh[c]  <= i_cfg_data[ACC_W-1:0];
            CFG_PHASE: r_phase_sh[c] <= i_cfg_data[PW-1:0];
            CFG_AMP:   r_amp_sh[c]   <= i_cfg_data[AMP_W-1:0];
            default:   ;
          endcase
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_acc_next[c] = r_acc[c] + r_freq_sh[c];
    end
  end

  // The scan reads only the per-tick snapshot, so a sync mid-scan cannot disturb it
  // and the shadows need no separate commit stage on sync.
  always_ff @(posedge i_src_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c]        <= '0;
        r_scan_pos[c]   <= '0;
        r_scan_phase[c] <= '0;
        r_scan_amp[c]   <= '1;
      end
    end else if (i_sync) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c] <= '0;
      end
    end else if (w_accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c]        <= w_acc_next[c];
        r_scan_pos[c]   <= w_acc_next[c][ACC_W-1 -: PW];
        r_scan_phase[c] <= r_phase_sh[c];
        r_scan_amp[c]   <= r_amp_sh[c];
      end
    end
  end

  always_ff @(posedge i_src_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_scan_ch   <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= SCAN;
            r_scan_ch <= '0;
            r_busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (r_scan_ch == CH_LAST) begin
            r_state     <= DRAIN;
            r_drain_cnt <= '0;
          end else begin
            r_scan_ch <= r_scan_ch + 4'd1;
          end
        end
        DRAIN: begin
          if (r_drain_cnt == 2'd2) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_src_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_overrun <= 1'b1;
    end else if (i_cfg_we && i_cfg_sel == CFG_CLR) begin
      r_overrun <= 1'b0;
    end
  end

  logic [PW-1:0]     w_pos;
  logic [PW-1:0]     w_phase;
  logic [AMP_W-1:0]  w_amp;
  logic [PW-1:0]     w_p;
  logic [1:0]        w_q;
  logic [LUT_AW-1:0] w_i;
  logic [LUT_AW-1:0] w_addr;

  always_comb begin
    w_pos   = '0;
    w_phase = '0;
    w_amp   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (r_scan_ch == 4'(c)) begin
        w_pos   = r_scan_pos[c];
        w_phase = r_scan_phase[c];
        w_amp   = r_scan_amp[c];
      end
    end
  end

  assign w_p    = w_pos + w_phase;
  assign w_q    = w_p[PW-1 -: 2];
  assign w_i    = w_p[LUT_AW-1:0];
  assign w_addr = (w_q == Q1 || w_q == Q3) ? ~w_i : w_i;

  logic              r_s1_valid;
  logic [3:0]        r_s1_ch;
  logic [1:0]        r_s1_q;
  logic [LUT_AW-1:0] r_s1_addr;
  logic [AMP_W-1:0]  r_s1_amp;
  logic              r_s2_valid;
  logic [3:0]        r_s2_ch;
  logic [1:0]        r_s2_q;
  logic [AMP_W-1:0]  r_s2_amp;
  logic [OUT_W-1:0]  w_rom_data;
  logic [OUT_W-1:0]  r_sample;
  logic [3:0]        r_sample_ch;
  logic              r_sample_valid;

  quarter_sine_rom #(
    .LUT_AW(LUT_AW),
    .OUT_W (OUT_W)
  ) u_rom (
    .i_clk (i_src_clk),
    .i_addr(r_s1_addr),
    .o_data(w_rom_data)
  );

  logic [AMP_W:0]       w_amp_p1;
  logic [OUT_W+AMP_W:0] w_prod;
  logic [OUT_W-1:0]     w_mag;

  // amp+1 lets the all-ones code pass the table value through unscaled.
  assign w_amp_p1 = {1'b0, r_s2_amp} + (AMP_W+1)'(1);
  assign w_prod   = (OUT_W+AMP_W+1)'(w_rom_data) * (OUT_W+AMP_W+1)'(w_amp_p1);
  assign w_mag    = OUT_W'(w_prod >> AMP_W);

  always_ff @(posedge i_src_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid     <= 1'b0;
      r_s1_ch        <= '0;
      r_s1_q         <= '0;
      r_s1_addr      <= '0;
      r_s1_amp       <= '0;
      r_s2_valid     <= 1'b0;
      r_s2_ch        <= '0;
      r_s2_q         <= '0;
      r_s2_amp       <= '0;
      r_sample       <= MID;
      r_sample_ch    <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_s1_valid     <= (r_state == SCAN);
      r_s1_ch        <= r_scan_ch;
      r_s1_q         <= w_q;
      r_s1_addr      <= w_addr;
      r_s1_amp       <= w_amp;
      r_s2_valid     <= r_s1_valid;
      r_s2_ch        <= r_s1_ch;
      r_s2_q         <= r_s1_q;
      r_s2_amp       <= r_s1_amp;
      r_sample_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_sample    <= (r_s2_q == Q2 || r_s2_q == Q3) ? MID - w_mag : MID + w_mag;
        r_sample_ch <= r_s2_ch;
      end
    end
  end

  assign o_sample       = r_sample;
  assign o_sample_ch    = r_sample_ch;
  assign o_sample_valid = r_sample_valid;
  assign o_busy         = r_busy;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_dds_nco_mc.sv
// tb/tb_dds_nco_mc.sv - directed self-checking bench for dds_nco_mc
module tb_dds_nco_mc;
  import dds_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        tick = 1'b0;
  logic        sync = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_ch = '0;
  logic [1:0]  cfg_sel = '0;
  logic [31:0] cfg_data = '0;
  logic [7:0]  o_sample;
  logic [3:0]  o_sample_ch;
  logic        o_sample_valid;
  logic        o_busy;
  logic        o_overrun;

  int checks = 0;
  int errors = 0;

  logic       cap_valid  [1:9];
  logic [7:0] cap_sample [1:9];
  logic [3:0] cap_ch     [1:9];
  logic       cap_busy   [1:9];
  logic       cap_ovr    [1:9];

  dds_nco_mc #(
    .CHANNELS(2), .ACC_W(32), .LUT_AW(8), .OUT_W(8), .AMP_W(8)
  ) dut (
    .i_src_clk(clk), .i_rst(rst), .i_en(en), .i_tick(tick), .i_sync(sync),
    .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch), .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data),
    .o_sample(o_sample), .o_sample_ch(o_sample_ch), .o_sample_valid(o_sample_valid),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  task automatic cfg_write(input logic [3:0] ch, input logic [1:0] sel, input logic [31:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_sync();
    @(negedge clk); sync = 1'b1;
    @(negedge clk); sync = 1'b0;
  endtask

  // action: 0 none, 1 ch0 freq write in cycle 1, 2 sync in cycle 1, 3 en low from cycle 1, 4 extra tick in cycle 3
  task automatic run_tick(input int action);
    @(negedge clk); tick = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tick = 1'b0;
        case (action)
          1: begin cfg_we = 1'b1; cfg_ch = 4'd0; cfg_sel = CFG_FREQ; cfg_data = 32'h8000_0000; end
          2: sync = 1'b1;
          3: en = 1'b0;
          default: ;
        endcase
      end
      if (c == 2) begin cfg_we = 1'b0; sync = 1'b0; end
      if (c == 3 && action == 4) tick = 1'b1;
      if (c == 4) tick = 1'b0;
      cap_valid[c] = o_sample_valid; cap_sample[c] = o_sample; cap_ch[c] = o_sample_ch;
      cap_busy[c] = o_busy; cap_ovr[c] = o_overrun;
    end
    en = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (o_sample !== 8'd128 || o_sample_valid !== 1'b0) begin errors++;
      $display("FAIL reset_held: sample=%0d valid=%0d expected 128/0", o_sample, o_sample_valid); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_sample !== 8'd128) begin errors++; $display("FAIL reset_sample: got %0d expected 128", o_sample); end
    checks++; if (o_sample_ch !== 4'd0) begin errors++; $display("FAIL reset_ch: got %0d expected 0", o_sample_ch); end
    checks++; if (o_sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", o_sample_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", o_busy); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0d expected 0", o_overrun); end
  endtask

  task automatic test_freq_sweep();
    logic [7:0] exp0 [4];
    exp0 = '{8'd255, 8'd128, 8'd1, 8'd128};
    cfg_write(4'd0, CFG_FREQ, 32'h4000_0000);
    for (int t = 0; t < 4; t++) begin
      run_tick(0);
      checks++; if (cap_valid[3] !== 1'b0 || cap_valid[4] !== 1'b1 || cap_ch[4] !== 4'd0) begin errors++;
        $display("FAIL sweep_ch0_timing t%0d: valid3=%0d valid4=%0d ch=%0d expected 0/1/0", t, cap_valid[3], cap_valid[4], cap_ch[4]); end
      checks++; if (cap_sample[4] !== exp0[t]) begin errors++;
        $display("FAIL sweep_ch0 t%0d: got %0d expected %0d", t, cap_sample[4], exp0[t]); end
      checks++; if (cap_valid[5] !== 1'b1 || cap_ch[5] !== 4'd1 || cap_sample[5] !== 8'd128) begin errors++;
        $display("FAIL sweep_ch1 t%0d: valid=%0d ch=%0d sample=%0d expected 1/1/128", t, cap_valid[5], cap_ch[5], cap_sample[5]); end
      checks++; if (cap_valid[6] !== 1'b0 || cap_ch[7] !== 4'd1 || cap_sample[7] !== 8'd128) begin errors++;
        $display("FAIL sweep_hold t%0d: valid6=%0d ch7=%0d sample7=%0d expected 0/1/128", t, cap_valid[6], cap_ch[7], cap_sample[7]); end
      if (t == 0) begin
        checks++; if (cap_busy[1] !== 1'b1 || cap_busy[5] !== 1'b1 || cap_busy[6] !== 1'b0) begin errors++;
          $display("FAIL sweep_busy: c1=%0d c5=%0d c6=%0d expected 1/1/0", cap_busy[1], cap_busy[5], cap_busy[6]); end
      end
    end
  endtask

  task automatic test_phase_amp();
    logic [7:0] exp0 [4];
    logic [7:0] exp1 [4];
    exp0 = '{8'd128, 8'd128, 8'd218, 8'd38};
    exp1 = '{8'd255, 8'd191, 8'd191, 8'd191};
    cfg_write(4'd0, CFG_FREQ, 32'h0);
    cfg_write(4'd1, CFG_PHASE, 32'd256);
    for (int s = 0; s < 4; s++) begin
      if (s == 1) cfg_write(4'd1, CFG_AMP, 32'd127);
      if (s == 2) cfg_write(4'd0, CFG_PHASE, 32'd128);
      if (s == 3) cfg_write(4'd0, CFG_PHASE, 32'd640);
      run_tick(0);
      checks++; if (cap_valid[4] !== 1'b1 || cap_sample[4] !== exp0[s]) begin errors++;
        $display("FAIL phase_amp_ch0 s%0d: valid=%0d got %0d expected %0d", s, cap_valid[4], cap_sample[4], exp0[s]); end
      checks++; if (cap_valid[5] !== 1'b1 || cap_sample[5] !== exp1[s]) begin errors++;
        $display("FAIL phase_amp_ch1 s%0d: valid=%0d got %0d expected %0d", s, cap_valid[5], cap_sample[5], exp1[s]); end
    end
  endtask

  task automatic test_overrun();
    int nv;
    run_tick(4);
    nv = 0;
    for (int c = 1; c <= 9; c++) if (cap_valid[c] === 1'b1) nv++;
    checks++; if (cap_ovr[3] !== 1'b0 || cap_ovr[4] !== 1'b1 || cap_ovr[9] !== 1'b1) begin errors++;
      $display("FAIL overrun_set: c3=%0d c4=%0d c9=%0d expected 0/1/1", cap_ovr[3], cap_ovr[4], cap_ovr[9]); end
    checks++; if (nv != 2 || cap_busy[6] !== 1'b0) begin errors++;
      $display("FAIL overrun_drop: valid_count=%0d busy6=%0d expected 2/0", nv, cap_busy[6]); end
    checks++; if (cap_sample[4] !== 8'd38) begin errors++;
      $display("FAIL overrun_sample: got %0d expected 38", cap_sample[4]); end
    cfg_write(4'd7, CFG_CLR, 32'h0);
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %0d expected 0", o_overrun); end
  endtask

  task automatic test_midscan_cfg_sync();
    int nv;
    int nb;
    int no;
    cfg_write(4'd0, CFG_PHASE, 32'd0);
    cfg_write(4'd1, CFG_PHASE, 32'd0);
    cfg_write(4'd1, CFG_AMP, 32'd255);
    cfg_write(4'd0, CFG_FREQ, 32'h4000_0000);
    cfg_write(4'd1, CFG_FREQ, 32'h4000_0000);
    pulse_sync();
    run_tick(1);
    checks++; if (cap_sample[4] !== 8'd255 || cap_sample[5] !== 8'd255) begin errors++;
      $display("FAIL midscan_write_current: ch0=%0d ch1=%0d expected 255/255", cap_sample[4], cap_sample[5]); end
    run_tick(0);
    checks++; if (cap_sample[4] !== 8'd1 || cap_sample[5] !== 8'd128) begin errors++;
      $display("FAIL midscan_write_next: ch0=%0d ch1=%0d expected 1/128", cap_sample[4], cap_sample[5]); end
    @(negedge clk); sync = 1'b1; tick = 1'b1;
    @(negedge clk); sync = 1'b0; tick = 1'b0;
    nv = 0; nb = 0; no = 0;
    for (int c = 0; c < 8; c++) begin
      if (o_sample_valid) nv++;
      if (o_busy) nb++;
      if (o_overrun) no++;
      @(negedge clk);
    end
    checks++; if (nv != 0 || nb != 0) begin errors++;
      $display("FAIL sync_tick_drop: valid_count=%0d busy_count=%0d expected 0/0", nv, nb); end
    checks++; if (no != 0) begin errors++; $display("FAIL sync_tick_overrun: count=%0d expected 0", no); end
    run_tick(2);
    checks++; if (cap_sample[4] !== 8'd128 || cap_sample[5] !== 8'd255) begin errors++;
      $display("FAIL sync_zero_and_latched: ch0=%0d ch1=%0d expected 128/255", cap_sample[4], cap_sample[5]); end
    run_tick(0);
    checks++; if (cap_sample[4] !== 8'd128 || cap_sample[5] !== 8'd255) begin errors++;
      $display("FAIL midscan_sync_after: ch0=%0d ch1=%0d expected 128/255", cap_sample[4], cap_sample[5]); end
  endtask

  task automatic test_enable();
    int nv;
    int nb;
    cfg_write(4'd0, CFG_FREQ, 32'h4000_0000);
    cfg_write(4'd1, CFG_FREQ, 32'h0);
    pulse_sync();
    en = 1'b0;
    nv = 0; nb = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); tick = 1'b1;
      if (o_sample_valid) nv++;
      if (o_busy) nb++;
      @(negedge clk); tick = 1'b0;
      if (o_sample_valid) nv++;
      if (o_busy) nb++;
    end
    repeat (4) begin
      @(negedge clk);
      if (o_sample_valid) nv++;
      if (o_busy) nb++;
    end
    checks++; if (nv != 0 || nb != 0 || o_overrun !== 1'b0) begin errors++;
      $display("FAIL enable_low: valid_count=%0d busy_count=%0d overrun=%0d expected 0/0/0", nv, nb, o_overrun); end
    en = 1'b1;
    run_tick(3);
    checks++; if (cap_valid[4] !== 1'b1 || cap_sample[4] !== 8'd255 || cap_valid[5] !== 1'b1 || cap_sample[5] !== 8'd128) begin errors++;
      $display("FAIL enable_frozen: v4=%0d ch0=%0d v5=%0d ch1=%0d expected 1/255/1/128", cap_valid[4], cap_sample[4], cap_valid[5], cap_sample[5]); end
    cfg_write(4'd5, CFG_PHASE, 32'd256);
    run_tick(0);
    checks++; if (cap_sample[4] !== 8'd128 || cap_sample[5] !== 8'd128) begin errors++;
      $display("FAIL bad_channel_write: ch0=%0d ch1=%0d expected 128/128", cap_sample[4], cap_sample[5]); end
  endtask

  task automatic test_reset_midscan();
    int nv;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    checks++; if (o_sample_valid !== 1'b1 || o_sample !== 8'd1 || o_overrun !== 1'b1) begin errors++;
      $display("FAIL pre_reset_scan: valid=%0d sample=%0d overrun=%0d expected 1/1/1", o_sample_valid, o_sample, o_overrun); end
    #2 rst = 1'b1;
    #1;
    checks++; if (o_sample !== 8'd128 || o_sample_ch !== 4'd0 || o_sample_valid !== 1'b0) begin errors++;
      $display("FAIL async_reset_out: sample=%0d ch=%0d valid=%0d expected 128/0/0", o_sample, o_sample_ch, o_sample_valid); end
    checks++; if (o_busy !== 1'b0 || o_overrun !== 1'b0) begin errors++;
      $display("FAIL async_reset_flags: busy=%0d overrun=%0d expected 0/0", o_busy, o_overrun); end
    @(negedge clk); rst = 1'b0;
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_sample_valid) nv++;
    end
    checks++; if (nv != 0 || o_busy !== 1'b0) begin errors++;
      $display("FAIL reset_flush: valid_count=%0d busy=%0d expected 0/0", nv, o_busy); end
  endtask

  initial begin
    test_reset();
    test_freq_sweep();
    test_phase_amp();
    test_overrun();
    test_midscan_cfg_sync();
    test_enable();
    test_reset_midscan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
